// File: rtl/widen_pack.sv
// widen_pack: collects narrow multi-lane beats and packs them into one
// full-width word of CHUNKS chunks for a wide consumer.
//
// Optional feature (macro WIDEN_PACK_LAST_EN): adds i_last / t_last so a
// word can be closed early, with the unfilled upper slots forced to zero.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_req/i_ack    input beat handshake, i_data holds IN_LANES chunks
//   t_req/t_ack    packed word handshake, t_data holds CHUNKS chunks
//   mode           lanes per beat, one-hot in mode[STEPS-1:0] (1, 2 or 4)
//   busy           partial word held or output word valid
//   i_last/t_last  (WIDEN_PACK_LAST_EN only) early word close / marker
//
// state | meaning
// ------+-----------------------------------------------------------
//   0   | no partial word; lanes per beat taken from live mode
//   n   | slots 0..n-1 of the current word filled; next beat lands at n
module widen_pack #(
    parameter int CHUNK_W  = 128,
    parameter int CHUNKS   = 8,
    parameter int IN_LANES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
`ifdef WIDEN_PACK_LAST_EN
    input  logic                        i_last,
    output logic                        t_last,
`endif
    input  logic                        i_req,
    output logic                        i_ack,
    input  logic [IN_LANES*CHUNK_W-1:0] i_data,
    output logic                        t_req,
    input  logic                        t_ack,
    output logic [CHUNKS*CHUNK_W-1:0]   t_data,
    input  logic [7:0]                  mode,
    output logic                        busy
);

    localparam int STEPS    = $clog2(CHUNKS);
    // One extra bit so that the wrap point (state + reduct == CHUNKS) is
    // visible and a lane count equal to CHUNKS still fits.
    localparam int RW       = STEPS + 1;
    localparam int LANE_LOG = $clog2(IN_LANES);
    localparam logic [RW-1:0] WRAP = RW'(CHUNKS);

    logic [STEPS-1:0]          state;
    logic [RW-1:0]             reduct_q;
    logic [RW-1:0]             reduct_dec;
    logic [RW-1:0]             reduct;
    logic [CHUNKS*CHUNK_W-1:0] acc;
    logic [CHUNKS*CHUNK_W-1:0] merged;
    logic                      wrap_hit;
    logic                      last_beat;
    logic                      accept;
    logic                      unused_mode;

    assign unused_mode = ^mode;

    // Highest set bit wins; bits beyond the available lane count are ignored.
    always_comb begin
        reduct_dec = '0;
        for (int k = 0; k <= LANE_LOG; k++) begin
            if (k < STEPS && mode[k]) begin
                reduct_dec = RW'(1) << k;
            end
        end
    end

    // Lane count is frozen for the remainder of a word once it has started.
    assign reduct   = (state == '0) ? reduct_dec : reduct_q;
    assign wrap_hit = ({1'b0, state} + reduct) == WRAP;

`ifdef WIDEN_PACK_LAST_EN
    assign last_beat = wrap_hit | i_last;
`else
    assign last_beat = wrap_hit;
`endif

    // Mid-word beats never stall; only the closing beat waits for the
    // output register to be free (or freed in the same cycle).
    always_comb begin
        i_ack = 1'b0;
        if (reset_n && reduct != '0) begin
            i_ack = last_beat ? (~t_req | t_ack) : 1'b1;
        end
    end

    assign accept = i_req & i_ack;

    // Slots below state come from the accumulator, the current beat fills
    // state..state+reduct-1, and everything above is zero. On a normal wrap
    // there is nothing above, so the same word serves the early-close case.
    always_comb begin
        merged = '0;
        for (int s = 0; s < CHUNKS; s++) begin
            int lane;
            lane = s - int'(state);
            if (s < int'(state)) begin
                merged[s*CHUNK_W +: CHUNK_W] = acc[s*CHUNK_W +: CHUNK_W];
            end else if (lane < int'(reduct) && lane < IN_LANES) begin
                merged[s*CHUNK_W +: CHUNK_W] = i_data[lane*CHUNK_W +: CHUNK_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= '0;
            reduct_q <= '0;
            acc      <= '0;
            t_req    <= 1'b0;
            t_data   <= '0;
`ifdef WIDEN_PACK_LAST_EN
            t_last   <= 1'b0;
`endif
        end else begin
            if (accept && state == '0) begin
                reduct_q <= reduct;
            end

            if (accept && last_beat) begin
                t_data <= merged;
                state  <= '0;
`ifdef WIDEN_PACK_LAST_EN
                t_last <= i_last;
`endif
            end else if (accept) begin
                acc   <= merged;
                state <= state + reduct[STEPS-1:0];
            end

            if (accept && last_beat) begin
                t_req <= 1'b1;
            end else if (t_ack) begin
                t_req <= 1'b0;
            end
        end
    end

    assign busy = (state != '0) | t_req;

endmodule

// File: tb/tb_widen_pack.sv
module tb_widen_pack;

    localparam int CHUNK_W  = 128;
    localparam int CHUNKS   = 8;
    localparam int IN_LANES = 4;
    localparam int TW = CHUNKS * CHUNK_W;
    localparam int IW = IN_LANES * CHUNK_W;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_req = 1'b0;
    logic          i_ack;
    logic [IW-1:0] i_data = '0;
    logic          t_req;
    logic          t_ack = 1'b0;
    logic [TW-1:0] t_data;
    logic [7:0]    mode = 8'h00;
    logic          busy;
`ifdef WIDEN_PACK_LAST_EN
    logic          i_last = 1'b0;
    logic          t_last;
`endif

    widen_pack #(.CHUNK_W(CHUNK_W), .CHUNKS(CHUNKS), .IN_LANES(IN_LANES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef WIDEN_PACK_LAST_EN
        .i_last  (i_last),
        .t_last  (t_last),
`endif
        .i_req   (i_req),
        .i_ack   (i_ack),
        .i_data  (i_data),
        .t_req   (t_req),
        .t_ack   (t_ack),
        .t_data  (t_data),
        .mode    (mode),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       req;
        logic [7:0] md;
        int         d;
        logic       ack;
        logic       e_iack;
        logic       e_treq;
        logic       e_busy;
        int         wbase;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_word(input string nm, input logic [TW-1:0] exp);
        total++;
        if (t_data !== exp) begin
            bad++;
            for (int s = 0; s < CHUNKS; s++) begin
                if (t_data[s*CHUNK_W +: CHUNK_W] !== exp[s*CHUNK_W +: CHUNK_W]) begin
                    $display("FAIL %s: slot %0d got %h want %h", nm, s,
                             t_data[s*CHUNK_W +: CHUNK_W], exp[s*CHUNK_W +: CHUNK_W]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [TW-1:0] seq(input int base);
        logic [TW-1:0] w;
        for (int s = 0; s < CHUNKS; s++) w[s*CHUNK_W +: CHUNK_W] = CHUNK_W'(base + s);
        return w;
    endfunction

    task automatic set_lanes(input int d);
        for (int j = 0; j < IN_LANES; j++) i_data[j*CHUNK_W +: CHUNK_W] = CHUNK_W'(d + j);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge.
    task automatic drv(input logic req, input logic [7:0] md, input int d, input logic ack);
        i_req = req;
        mode  = md;
        set_lanes(d);
        t_ack = ack;
        #4;
    endtask

    task automatic cyc_end;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic req, input logic [7:0] md, input int d,
                                input logic ack, input logic ei, input logic et,
                                input logic eb, input int wb);
        vec_t v;
        v.req = req; v.md = md; v.d = d; v.ack = ack;
        v.e_iack = ei; v.e_treq = et; v.e_busy = eb; v.wbase = wb;
        return v;
    endfunction

    function automatic int lanes_of(input logic [7:0] m);
        if (m[2]) return 4;
        if (m[1]) return 2;
        if (m[0]) return 1;
        return 0;
    endfunction

    // reference model state
    int                 m_pos;
    int                 m_lanes_q;
    logic               m_ov;
    logic               m_olast;
    logic [TW-1:0]      m_ow;
    logic [CHUNK_W-1:0] m_slot [CHUNKS];

    initial begin
        logic [7:0] picks [11];
        picks = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h03, 8'h06, 8'h07, 8'h05, 8'hF0, 8'h0C, 8'h08};

        // reset state, with a legal request pending
        mode = 8'h04;
        i_req = 1'b1;
        set_lanes(8'h10);
        #3;
        chk("rst_iack", i_ack, 0);
        chk("rst_treq", t_req, 0);
        chk("rst_busy", busy, 0);
        chk_word("rst_tdata", '0);
        cyc_end;
        cyc_end;
        i_req = 1'b0;
        reset_n = 1'b1;
        cyc_end;

        // 4 lanes: two beats make one word
        tbl.push_back(mk(1, 8'h04, 'h10, 0, 1, 0, 0, -1));
        tbl.push_back(mk(1, 8'h04, 'h14, 0, 1, 0, 1, -1));
        tbl.push_back(mk(0, 8'h04, 0,    0, 1, 1, 1, 'h10));
        tbl.push_back(mk(0, 8'h04, 0,    1, 1, 1, 1, 'h10));
        tbl.push_back(mk(0, 8'h04, 0,    0, 1, 0, 0, -1));
        // 1 lane: eight beats, t_ack held high, never stalls
        for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 8'h01, k, 1, 1, 0, k != 0, -1));
        tbl.push_back(mk(0, 8'h01, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 8'h01, 0, 0, 1, 0, 0, -1));
        // illegal modes never accept
        for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 8'h00, 'h99, 0, 0, 0, 0, -1));
        tbl.push_back(mk(1, 8'hF8, 'h99, 0, 0, 0, 0, -1));
        // several bits set: highest wins (4 lanes)
        tbl.push_back(mk(1, 8'h06, 'h20, 0, 1, 0, 0, -1));
        tbl.push_back(mk(1, 8'h06, 'h24, 0, 1, 0, 1, -1));
        tbl.push_back(mk(0, 8'h00, 0,    1, 0, 1, 1, 'h20));
        tbl.push_back(mk(0, 8'h00, 0,    0, 0, 0, 0, -1));

        foreach (tbl[i]) begin
            drv(tbl[i].req, tbl[i].md, tbl[i].d, tbl[i].ack);
            chk($sformatf("vec%0d_iack", i), i_ack, tbl[i].e_iack);
            chk($sformatf("vec%0d_treq", i), t_req, tbl[i].e_treq);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].wbase >= 0) chk_word($sformatf("vec%0d_word", i), seq(tbl[i].wbase));
            cyc_end;
        end

        // back-to-back words, first word not acknowledged
        drv(1, 8'h04, 'h30, 0); chk("b2b_a_iack", i_ack, 1); cyc_end;
        drv(1, 8'h04, 'h34, 0); chk("b2b_b_iack", i_ack, 1); cyc_end;
        drv(1, 8'h04, 'h50, 0);
        chk("b2b_c_iack", i_ack, 1);
        chk("b2b_c_treq", t_req, 1);
        chk_word("b2b_w1", seq('h30));
        cyc_end;
        for (int k = 0; k < 3; k++) begin
            drv(1, 8'h04, 'h54, 0);
            chk("b2b_stall_iack", i_ack, 0);
            chk("b2b_stall_treq", t_req, 1);
            chk_word("b2b_stall_w1", seq('h30));
            cyc_end;
        end
        drv(1, 8'h04, 'h54, 1); chk("b2b_rel_iack", i_ack, 1); cyc_end;
        drv(0, 8'h04, 0, 0);
        chk("b2b_w2_treq", t_req, 1);
        chk_word("b2b_w2", seq('h50));
        cyc_end;
        drv(0, 8'h04, 0, 1); cyc_end;
        drv(0, 8'h04, 0, 0);
        chk("b2b_end_treq", t_req, 0);
        chk("b2b_end_busy", busy, 0);
        cyc_end;

        // mode switched 2 -> 1 after the first beat
        drv(1, 8'h02, 'h40, 0); chk("msw_iack0", i_ack, 1); cyc_end;
        for (int k = 1; k < 4; k++) begin
            drv(1, 8'h01, 'h40 + 2 * k, 0); chk("msw_iack", i_ack, 1); cyc_end;
        end
        drv(0, 8'h01, 0, 1);
        chk("msw_w1_treq", t_req, 1);
        chk_word("msw_w1", seq('h40));
        cyc_end;
        for (int k = 0; k < 8; k++) begin
            drv(1, 8'h01, 'h60 + k, 0);
            if (k == 4) begin
                chk("msw_half_treq", t_req, 0);
                chk("msw_half_busy", busy, 1);
            end
            chk("msw_1lane_iack", i_ack, 1);
            cyc_end;
        end
        drv(0, 8'h01, 0, 0);
        chk("msw_w2_treq", t_req, 1);
        chk_word("msw_w2", seq('h60));
        cyc_end;
        drv(0, 8'h01, 0, 1); cyc_end;

`ifdef WIDEN_PACK_LAST_EN
        // early close on beat 2 at 2 lanes
        drv(1, 8'h02, 'h90, 0); cyc_end;
        i_last = 1'b1;
        drv(1, 8'h02, 'h92, 0); chk("last_iack", i_ack, 1); cyc_end;
        i_last = 1'b0;
        drv(0, 8'h02, 0, 0);
        chk("last_treq", t_req, 1);
        chk("last_tlast", t_last, 1);
        begin
            logic [TW-1:0] w;
            w = '0;
            for (int s = 0; s < 4; s++) w[s*CHUNK_W +: CHUNK_W] = CHUNK_W'('h90 + s);
            chk_word("last_word", w);
        end
        cyc_end;
        drv(0, 8'h02, 0, 1); cyc_end;
        drv(1, 8'h04, 'hA0, 0); cyc_end;
        drv(1, 8'h04, 'hA4, 0); cyc_end;
        drv(0, 8'h04, 0, 1);
        chk("last_norm_tlast", t_last, 0);
        chk_word("last_norm_word", seq('hA0));
        cyc_end;
`endif

        // reset after 3 of 4 beats
        for (int k = 0; k < 3; k++) begin
            drv(1, 8'h02, 'h70 + 2 * k, 0); cyc_end;
        end
        i_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rmid_treq", t_req, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_iack", i_ack, 0);
        cyc_end;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(1, 8'h02, 'h80 + 2 * k, 0);
            if (k == 0) chk("rpost_busy", busy, 0);
            chk("rpost_iack", i_ack, 1);
            cyc_end;
        end
        drv(0, 8'h02, 0, 0);
        chk("rpost_treq", t_req, 1);
        chk_word("rpost_word", seq('h80));
        cyc_end;
        // reset while the output word is valid
        reset_n = 1'b0;
        #1;
        chk("rout_treq", t_req, 0);
        chk_word("rout_tdata", '0);
        cyc_end;
        reset_n = 1'b1;

        // randomized run against the reference model
        m_pos = 0; m_lanes_q = 0; m_ov = 1'b0; m_olast = 1'b0; m_ow = '0;
        for (int s = 0; s < CHUNKS; s++) m_slot[s] = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic il, last, e_iack, acc_b;
            int   ln;
            i_req = ($urandom_range(0, 3) != 0);
            t_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 11) == 0) mode = picks[$urandom_range(0, 10)];
            for (int w = 0; w < IW / 32; w++) i_data[w*32 +: 32] = $urandom;
            il = 1'b0;
`ifdef WIDEN_PACK_LAST_EN
            il = ($urandom_range(0, 9) == 0);
            i_last = il;
`endif
            #4;
            ln     = (m_pos == 0) ? lanes_of(mode) : m_lanes_q;
            last   = (ln != 0) && ((m_pos + ln == CHUNKS) || il);
            e_iack = (ln == 0) ? 1'b0 : (last ? (!m_ov || t_ack) : 1'b1);
            chk("rnd_iack", i_ack, e_iack);
            chk("rnd_treq", t_req, m_ov);
            chk("rnd_busy", busy, (m_pos != 0) || m_ov);
            chk_word("rnd_word", m_ow);
`ifdef WIDEN_PACK_LAST_EN
            chk("rnd_tlast", t_last, m_olast);
`endif
            acc_b = i_req && e_iack;
            if (m_ov && t_ack) m_ov = 1'b0;
            if (acc_b) begin
                for (int j = 0; j < ln; j++) m_slot[m_pos + j] = i_data[j*CHUNK_W +: CHUNK_W];
                if (m_pos == 0) m_lanes_q = ln;
                if (last) begin
                    for (int s = 0; s < CHUNKS; s++)
                        m_ow[s*CHUNK_W +: CHUNK_W] = (s < m_pos + ln) ? m_slot[s] : '0;
                    m_ov = 1'b1;
                    m_olast = il;
                    m_pos = 0;
                end else begin
                    m_pos = m_pos + ln;
                end
            end
            cyc_end;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
